// File: rtl/rpn_sequencer.sv
// Control sequencer for the 8-bit RPN ALU datapath: A/B/opcode entry, ALU settle,
// result store and chaining of the result back into operand A.
module rpn_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 3,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENTER,
  input  logic              CLEAR,
  input  logic [OP_W-1:0]   OP_CODE,
  input  logic [DATA_W:0]   ALU_RESULT,
  output logic              EN_A,
  output logic              EN_B,
  output logic              EN_RES,
  output logic              SEL_A_SRC,
  output logic [OP_W-1:0]   ALU_OP,
  output logic [2:0]        STATE,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW,
  output logic [7:0]        OP_COUNT
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_STORE   = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  localparam int             CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  function automatic logic data_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t             state_r, next_state_s;
  logic               enter_q_r;
  logic               enter_pulse_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               en_a_r, en_b_r, en_res_r, sel_a_src_r, busy_r, done_r, overflow_r;
  logic               en_a_s, en_b_s, en_res_s, sel_a_src_s, busy_s, done_s, overflow_s;
  logic [OP_W-1:0]    alu_op_r, alu_op_s;
  logic [7:0]         op_count_r, op_count_s;
  logic               alu_data_unused_s;

  // The sequencer only consumes the carry bit of the ALU result.
  assign alu_data_unused_s = data_parity(ALU_RESULT[DATA_W-1:0]);

  assign enter_pulse_s = ENTER & ~enter_q_r;

  // State register and ENTER edge history; history resets high so a held button is not an edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r   <= S_WAIT_A;
      enter_q_r <= 1'b1;
    end else begin
      state_r   <= next_state_s;
      enter_q_r <= ENTER;
    end
  end

  // Next-state logic; CLEAR overrides any ENTER step.
  always_comb begin
    next_state_s = S_WAIT_A;
    if (CLEAR) begin
      next_state_s = S_WAIT_A;
    end else begin
      case (state_r)
        S_WAIT_A:  next_state_s = enter_pulse_s ? S_WAIT_B : S_WAIT_A;
        S_WAIT_B:  next_state_s = enter_pulse_s ? S_WAIT_OP : S_WAIT_B;
        S_WAIT_OP: next_state_s = enter_pulse_s ? S_EXEC : S_WAIT_OP;
        S_EXEC:    next_state_s = (cnt_r == {CNT_W{1'b0}}) ? S_STORE : S_EXEC;
        S_STORE:   next_state_s = S_SHOW;
        S_SHOW:    next_state_s = enter_pulse_s ? S_WAIT_B : S_SHOW;
        default:   next_state_s = S_WAIT_A;
      endcase
    end
  end

  // Next values of the registered outputs, settle counter and status.
  always_comb begin
    en_a_s      = 1'b0;
    en_b_s      = 1'b0;
    en_res_s    = 1'b0;
    done_s      = 1'b0;
    sel_a_src_s = sel_a_src_r;
    alu_op_s    = alu_op_r;
    overflow_s  = overflow_r;
    cnt_s       = cnt_r;
    op_count_s  = op_count_r;
    if (CLEAR) begin
      alu_op_s   = {OP_W{1'b0}};
      overflow_s = 1'b0;
    end else begin
      case (state_r)
        S_WAIT_A: begin
          if (enter_pulse_s) begin
            en_a_s      = 1'b1;
            sel_a_src_s = 1'b0;
          end else begin
            en_a_s      = 1'b0;
          end
        end
        S_WAIT_B: begin
          en_b_s = enter_pulse_s;
        end
        S_WAIT_OP: begin
          if (enter_pulse_s) begin
            alu_op_s = OP_CODE;
            cnt_s    = CNT_LOAD;
          end else begin
            cnt_s    = cnt_r;
          end
        end
        S_EXEC: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            en_res_s = 1'b1;
          end
        end
        S_STORE: begin
          overflow_s = ALU_RESULT[DATA_W];
          op_count_s = op_count_r + 8'd1;
          done_s     = 1'b1;
        end
        S_SHOW: begin
          if (enter_pulse_s) begin
            en_a_s      = 1'b1;
            sel_a_src_s = 1'b1;
          end else begin
            en_a_s      = 1'b0;
          end
        end
        default: begin
          cnt_s = {CNT_W{1'b0}};
        end
      endcase
    end
    busy_s = (next_state_s == S_EXEC) || (next_state_s == S_STORE);
  end

  // Output and datapath-control registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      en_a_r      <= 1'b0;
      en_b_r      <= 1'b0;
      en_res_r    <= 1'b0;
      sel_a_src_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      alu_op_r    <= {OP_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      op_count_r  <= 8'd0;
    end else begin
      en_a_r      <= en_a_s;
      en_b_r      <= en_b_s;
      en_res_r    <= en_res_s;
      sel_a_src_r <= sel_a_src_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      overflow_r  <= overflow_s;
      alu_op_r    <= alu_op_s;
      cnt_r       <= cnt_s;
      op_count_r  <= op_count_s;
    end
  end

  assign EN_A      = en_a_r;
  assign EN_B      = en_b_r;
  assign EN_RES    = en_res_r;
  assign SEL_A_SRC = sel_a_src_r;
  assign ALU_OP    = alu_op_r;
  assign STATE     = state_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign OVERFLOW  = overflow_r;
  assign OP_COUNT  = op_count_r;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: per-scenario tasks plus a DONE-driven scoreboard.
module tb_rpn_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET, ENTER, CLEAR;
  logic [2:0] OP_CODE;
  logic [8:0] ALU_RESULT;
  logic       EN_A, EN_B, EN_RES, SEL_A_SRC, BUSY, DONE, OVERFLOW;
  logic [2:0] ALU_OP, STATE;
  logic [7:0] OP_COUNT;

  typedef struct packed {
    logic       ovf;
    logic [7:0] cnt;
    logic [2:0] op;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] exp_count;
  int         tests = 0;
  int         fails = 0;

  rpn_sequencer #(.DATA_W(8), .OP_W(3), .EXEC_CYCLES(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENTER(ENTER), .CLEAR(CLEAR), .OP_CODE(OP_CODE),
    .ALU_RESULT(ALU_RESULT), .EN_A(EN_A), .EN_B(EN_B), .EN_RES(EN_RES),
    .SEL_A_SRC(SEL_A_SRC), .ALU_OP(ALU_OP), .STATE(STATE), .BUSY(BUSY), .DONE(DONE),
    .OVERFLOW(OVERFLOW), .OP_COUNT(OP_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Mid-cycle monitor: enable exclusivity and scoreboard pop on DONE.
  always @(negedge CLOCK) begin
    if (RESET === 1'b0) begin
      tests++;
      if ($countones({EN_A, EN_B, EN_RES}) > 1) begin
        fails++;
        $display("FAIL en_onehot: EN_A/B/RES=%b%b%b, want at most one high", EN_A, EN_B, EN_RES);
      end
      if (DONE === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: DONE=1 with no operation pending, want DONE=0");
        end else begin
          e = sb.pop_front();
          if ({OVERFLOW, OP_COUNT, ALU_OP} !== e) begin
            fails++;
            $display("FAIL sb_result: OVF=%b CNT=%0d OP=%0d, want OVF=%b CNT=%0d OP=%0d",
                     OVERFLOW, OP_COUNT, ALU_OP, e.ovf, e.cnt, e.op);
          end
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [8:0] res, input bit chained, input bit poke);
    int n;
    OP_CODE = op;
    ALU_RESULT = res;
    ENTER = 1'b1; tick();
    tests++;
    if (STATE !== 3'd1 || EN_A !== 1'b1 || EN_B !== 1'b0 || SEL_A_SRC !== chained) begin
      fails++;
      $display("FAIL op_enter_a: STATE=%0d EN_A=%b EN_B=%b SEL=%b, want 1/1/0/%b", STATE, EN_A, EN_B, SEL_A_SRC, chained);
    end
    ENTER = 1'b0; tick();
    ENTER = 1'b1; tick();
    tests++;
    if (STATE !== 3'd2 || EN_B !== 1'b1 || EN_A !== 1'b0 || SEL_A_SRC !== chained) begin
      fails++;
      $display("FAIL op_enter_b: STATE=%0d EN_B=%b EN_A=%b SEL=%b, want 2/1/0/%b", STATE, EN_B, EN_A, SEL_A_SRC, chained);
    end
    ENTER = 1'b0; tick();
    exp_count = exp_count + 8'd1;
    sb.push_back('{ovf: res[8], cnt: exp_count, op: op});
    ENTER = 1'b1; tick();
    tests++;
    if (STATE !== 3'd3 || BUSY !== 1'b1 || EN_A !== 1'b0 || EN_B !== 1'b0) begin
      fails++;
      $display("FAIL op_exec_entry: STATE=%0d BUSY=%b EN_A=%b EN_B=%b, want 3/1/0/0", STATE, BUSY, EN_A, EN_B);
    end
    n = 1;
    ENTER = 1'b0; tick();
    while (STATE === 3'd3 && n < 20) begin
      n++;
      ENTER = (poke && n == 2) ? 1'b1 : 1'b0;
      tick();
    end
    ENTER = 1'b0;
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL op_exec_dwell: %0d cycles in S_EXEC, want 2", n);
    end
    tests++;
    if (STATE !== 3'd4 || EN_RES !== 1'b1 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL op_store: STATE=%0d EN_RES=%b BUSY=%b, want 4/1/1", STATE, EN_RES, BUSY);
    end
    tick();
    tests++;
    if (STATE !== 3'd5 || DONE !== 1'b1 || BUSY !== 1'b0 || EN_RES !== 1'b0) begin
      fails++;
      $display("FAIL op_show: STATE=%0d DONE=%b BUSY=%b EN_RES=%b, want 5/1/0/0", STATE, DONE, BUSY, EN_RES);
    end
    tick();
    tests++;
    if (STATE !== 3'd5 || DONE !== 1'b0 || EN_A !== 1'b0) begin
      fails++;
      $display("FAIL op_show_hold: STATE=%0d DONE=%b EN_A=%b, want 5/0/0", STATE, DONE, EN_A);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENTER = 1'b1; CLEAR = 1'b0; OP_CODE = 3'd0; ALU_RESULT = 9'd0;
    exp_count = 8'd0;
    tick(); tick(); tick();
    tests++;
    if ({EN_A, EN_B, EN_RES, SEL_A_SRC, BUSY, DONE, OVERFLOW} !== 7'd0 || ALU_OP !== 3'd0 ||
        STATE !== 3'd0 || OP_COUNT !== 8'd0) begin
      fails++;
      $display("FAIL reset_values: flags=%b ALU_OP=%0d STATE=%0d CNT=%0d, want all 0",
               {EN_A, EN_B, EN_RES, SEL_A_SRC, BUSY, DONE, OVERFLOW}, ALU_OP, STATE, OP_COUNT);
    end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (EN_A !== 1'b0 || STATE !== 3'd0) begin
        fails++;
        $display("FAIL reset_held_enter: EN_A=%b STATE=%0d, want 0/0", EN_A, STATE);
      end
    end
    ENTER = 1'b0; tick();
  endtask

  task automatic test_full_op();
    run_op(3'b000, 9'h10F, 1'b0, 1'b0);
    tests++;
    if (OVERFLOW !== 1'b1 || OP_COUNT !== 8'd1 || STATE !== 3'd5) begin
      fails++;
      $display("FAIL full_op: OVF=%b CNT=%0d STATE=%0d, want 1/1/5", OVERFLOW, OP_COUNT, STATE);
    end
  endtask

  task automatic test_chaining();
    run_op(3'b110, 9'h155, 1'b1, 1'b0);
    tests++;
    if (SEL_A_SRC !== 1'b1 || ALU_OP !== 3'b110 || OP_COUNT !== 8'd2) begin
      fails++;
      $display("FAIL chaining: SEL=%b ALU_OP=%0d CNT=%0d, want 1/6/2", SEL_A_SRC, ALU_OP, OP_COUNT);
    end
  endtask

  task automatic test_clear_priority();
    ENTER = 1'b1; tick(); ENTER = 1'b0; tick();
    ENTER = 1'b1; tick(); ENTER = 1'b0; tick();
    tests++;
    if (STATE !== 3'd2) begin
      fails++;
      $display("FAIL clear_setup: STATE=%0d, want 2", STATE);
    end
    OP_CODE = 3'b101; CLEAR = 1'b1; ENTER = 1'b1; tick();
    CLEAR = 1'b0;
    tests++;
    if (STATE !== 3'd0 || ALU_OP !== 3'd0 || OVERFLOW !== 1'b0 || {EN_A, EN_B, EN_RES} !== 3'd0 ||
        OP_COUNT !== exp_count || SEL_A_SRC !== 1'b1) begin
      fails++;
      $display("FAIL clear_priority: STATE=%0d ALU_OP=%0d OVF=%b EN=%b CNT=%0d SEL=%b, want 0/0/0/000/%0d/1",
               STATE, ALU_OP, OVERFLOW, {EN_A, EN_B, EN_RES}, OP_COUNT, SEL_A_SRC, exp_count);
    end
    tick();
    tests++;
    if (STATE !== 3'd0 || {EN_A, EN_B, EN_RES} !== 3'd0) begin
      fails++;
      $display("FAIL clear_no_pulse: STATE=%0d EN=%b, want 0/000", STATE, {EN_A, EN_B, EN_RES});
    end
    ENTER = 1'b0; tick();
  endtask

  task automatic test_held_button();
    int pulses = 0;
    ENTER = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (EN_A === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 1 || STATE !== 3'd1 || SEL_A_SRC !== 1'b0) begin
      fails++;
      $display("FAIL held_button: EN_A pulses=%0d STATE=%0d SEL=%b, want 1/1/0", pulses, STATE, SEL_A_SRC);
    end
    ENTER = 1'b0; tick();
    CLEAR = 1'b1; tick(); CLEAR = 1'b0; tick();
  endtask

  task automatic test_reset_mid_exec();
    int pulses = 0;
    OP_CODE = 3'b011; ALU_RESULT = 9'h1FF;
    ENTER = 1'b1; tick(); ENTER = 1'b0; tick();
    ENTER = 1'b1; tick(); ENTER = 1'b0; tick();
    ENTER = 1'b1; tick();
    tests++;
    if (STATE !== 3'd3 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL rst_exec_setup: STATE=%0d BUSY=%b, want 3/1", STATE, BUSY);
    end
    RESET = 1'b1; #1;
    exp_count = 8'd0;
    tests++;
    if ({EN_A, EN_B, EN_RES, SEL_A_SRC, BUSY, DONE, OVERFLOW} !== 7'd0 || ALU_OP !== 3'd0 ||
        STATE !== 3'd0 || OP_COUNT !== 8'd0) begin
      fails++;
      $display("FAIL rst_exec_async: flags=%b ALU_OP=%0d STATE=%0d CNT=%0d, want all 0",
               {EN_A, EN_B, EN_RES, SEL_A_SRC, BUSY, DONE, OVERFLOW}, ALU_OP, STATE, OP_COUNT);
    end
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (EN_A === 1'b1 || EN_RES === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || STATE !== 3'd0) begin
      fails++;
      $display("FAIL rst_exec_hold: pulses=%0d STATE=%0d, want 0/0", pulses, STATE);
    end
    ENTER = 1'b0; tick();
    ENTER = 1'b1; tick();
    tests++;
    if (EN_A !== 1'b1 || STATE !== 3'd1) begin
      fails++;
      $display("FAIL rst_exec_rearm: EN_A=%b STATE=%0d, want 1/1", EN_A, STATE);
    end
    ENTER = 1'b0; tick();
    CLEAR = 1'b1; tick(); CLEAR = 1'b0; tick();
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 256; i++) begin
      run_op(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)), i != 0, (i % 4) == 1);
    end
    tests++;
    if (OP_COUNT !== 8'd0) begin
      fails++;
      $display("FAIL counter_wrap: OP_COUNT=%0d, want 0", OP_COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_full_op();
    test_chaining();
    test_clear_priority();
    test_held_button();
    test_reset_mid_exec();
    test_counter_wrap();
    tick(); tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d results never produced, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
